wb_stage: RTL and testbench
===========================

Name: wb_stage

Overview:
- Writeback stage of the 5-stage pipeline. Sits directly downstream of the memory stage and consumes its memoryed req/ack handshake plus its rd/pc/inst/nocmt/skipcmt outputs.
- Latches one instruction, issues a single-cycle register-file write strobe and a single-cycle commit pulse for difftest, then hands off via a writebacked req/ack handshake.
- Keeps free-running cycle and retired-instruction counters.

Parameters:
- XLEN, 64, data/pc width.
- CNT_W, 64, width of cycle and instruction counters.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- i_wb_memoryed_req  in  1  upstream has a valid instruction.
- o_wb_memoryed_ack  out  1  wb_stage accepts it this cycle.
- o_wb_writebacked_req  out  1  wb_stage holds a valid instruction.
- i_wb_writebacked_ack  in  1  downstream accepts it.
- i_wb_pc  in  XLEN  instruction pc.
- i_wb_inst  in  32  instruction word.
- i_wb_rd  in  5  destination register.
- i_wb_rd_wen  in  1  destination write enable.
- i_wb_rd_wdata  in  XLEN  destination data.
- i_wb_nocmt  in  1  bubble; do not commit.
- i_wb_skipcmt  in  1  commit, but difftest must skip compare.
- o_wb_rd  out  5  regfile write index.
- o_wb_rd_wen  out  1  regfile write strobe, one cycle.
- o_wb_rd_wdata  out  XLEN  regfile write data.
- o_cmt_valid  out  1  commit pulse, one cycle.
- o_cmt_pc  out  XLEN  committed pc.
- o_cmt_inst  out  32  committed instruction.
- o_cmt_skip  out  1  latched skipcmt.
- o_cmt_wen  out  1  committed regfile write (rd_wen & rd!=0).
- o_cmt_wdest  out  5  committed rd.
- o_cmt_wdata  out  XLEN  committed data.
- o_cycle_cnt  out  CNT_W  cycles since reset.
- o_instr_cnt  out  CNT_W  retired instructions.

Behaviour:
- Reset (async, rst=1): all outputs and internal registers are 0. State is IDLE, fresh=0, and both counters are 0. Reset asserted mid-operation discards the held instruction; no strobe or commit is issued.
- Handshakes:
  - mem_hs = i_wb_memoryed_req & o_wb_memoryed_ack.
  - wb_hs = o_wb_writebacked_req & i_wb_writebacked_ack.
- States: IDLE and VALID.
  - o_wb_writebacked_req = (state==VALID).
  - o_wb_memoryed_ack = (state==IDLE) | wb_hs. This is combinational, so back-to-back transfers run without a bubble.
- Transitions:
  - IDLE & mem_hs: latch all i_wb_* inputs, go to VALID, set fresh=1.
  - VALID & wb_hs & mem_hs: relatch, stay in VALID, set fresh=1.
  - VALID & wb_hs & !mem_hs: go to IDLE.
  - VALID & !wb_hs: hold the latched data; fresh clears after its first cycle.
- Write/commit cycle: the first VALID cycle after a latch (fresh=1). Latency is 1 cycle from mem_hs to the strobe and the pulse.
  - o_wb_rd_wen = fresh & rd_wen & (rd!=0) & !nocmt. o_wb_rd and o_wb_rd_wdata carry the latched values, and are 0 whenever the strobe is low.
  - o_cmt_valid = fresh & !nocmt. The o_cmt_* fields are valid only while o_cmt_valid=1 and are 0 otherwise.
  - A downstream stall (ack low) never repeats the strobe or the pulse.
- nocmt=1 instruction: passes through the handshake normally, but produces no regfile write, no commit pulse and no instr_cnt increment.
- skipcmt=1 instruction: commits normally, with o_cmt_skip=1.
- rd=0 with rd_wen=1: no regfile strobe; commit is still issued, with o_cmt_wen=0.
- o_cycle_cnt: +1 every clock after reset; wraps modulo 2^CNT_W.
- o_instr_cnt: +1 on each o_cmt_valid cycle; wraps modulo 2^CNT_W.
- Both counter outputs are registered values.

Test Plan:
- Single add, rd=5, wdata=0x1234: mem_hs at cycle N gives o_wb_rd_wen=1, o_wb_rd=5, o_wb_rd_wdata=0x1234 and o_cmt_valid=1, all in cycle N+1 only. o_instr_cnt goes 0→1.
- Downstream stall: hold i_wb_writebacked_ack=0 for 4 cycles. The strobe and pulse occur exactly once, o_wb_memoryed_ack=0 throughout, and o_wb_writebacked_req stays at 1.
- Back-to-back stream: 3 instructions with ack tied high give 3 consecutive single-cycle commit pulses, no idle bubble, and o_instr_cnt=3.
- Commit filtering:
  - nocmt=1 gives no strobe, no pulse, and o_instr_cnt unchanged.
  - skipcmt=1 gives a pulse with o_cmt_skip=1.
  - rd=0 with rd_wen=1 gives a pulse with o_cmt_wen=0 and no regfile strobe.
- Async reset mid-hold: assert rst between clock edges while VALID. All outputs go to 0 immediately, with no commit on release, and o_cycle_cnt restarts at 0.
- Counter wrap (CNT_W=4): after 16 cycles o_cycle_cnt wraps 15→0. After 16 commits o_instr_cnt wraps 15→0.

Source files
------------

// File: rtl/wb_stage.sv
// Writeback stage: latches one instruction from the memory stage, fires a single-cycle
// regfile write strobe and difftest commit pulse, and keeps cycle/retired counters.
module wb_stage #(
   parameter int XLEN  = 64,
   parameter int CNT_W = 64
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_wb_memoryed_req,
   output logic             o_wb_memoryed_ack,
   output logic             o_wb_writebacked_req,
   input  logic             i_wb_writebacked_ack,
   input  logic [XLEN-1:0]  i_wb_pc,
   input  logic [31:0]      i_wb_inst,
   input  logic [4:0]       i_wb_rd,
   input  logic             i_wb_rd_wen,
   input  logic [XLEN-1:0]  i_wb_rd_wdata,
   input  logic             i_wb_nocmt,
   input  logic             i_wb_skipcmt,
   output logic [4:0]       o_wb_rd,
   output logic             o_wb_rd_wen,
   output logic [XLEN-1:0]  o_wb_rd_wdata,
   output logic             o_cmt_valid,
   output logic [XLEN-1:0]  o_cmt_pc,
   output logic [31:0]      o_cmt_inst,
   output logic             o_cmt_skip,
   output logic             o_cmt_wen,
   output logic [4:0]       o_cmt_wdest,
   output logic [XLEN-1:0]  o_cmt_wdata,
   output logic [CNT_W-1:0] o_cycle_cnt,
   output logic [CNT_W-1:0] o_instr_cnt
);

   localparam logic [0:0] S_IDLE  = 1'b0;
   localparam logic [0:0] S_VALID = 1'b1;
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [0:0]       r_state;
   logic             r_fresh;
   logic [XLEN-1:0]  r_pc;
   logic [31:0]      r_inst;
   logic [4:0]       r_rd;
   logic             r_rd_wen;
   logic [XLEN-1:0]  r_rd_wdata;
   logic             r_nocmt;
   logic             r_skipcmt;
   logic [CNT_W-1:0] r_cycle_cnt;
   logic [CNT_W-1:0] r_instr_cnt;

   logic w_mem_hs;
   logic w_wb_hs;
   logic w_rd_nz;
   logic w_wb_wen;
   logic w_cmt_valid;

   // Upstream ack is combinational on the downstream ack so a stream flows without bubbles;
   // it is forced low while reset is held so every output reads 0 during reset.
   assign o_wb_writebacked_req = (r_state == S_VALID);
   assign w_wb_hs              = o_wb_writebacked_req & i_wb_writebacked_ack;
   assign o_wb_memoryed_ack    = ~rst & ((r_state == S_IDLE) | w_wb_hs);
   assign w_mem_hs             = i_wb_memoryed_req & o_wb_memoryed_ack;

   assign w_rd_nz     = (r_rd != 5'd0);
   assign w_cmt_valid = r_fresh & ~r_nocmt;
   assign w_wb_wen    = w_cmt_valid & r_rd_wen & w_rd_nz;

   assign o_wb_rd_wen   = w_wb_wen;
   assign o_wb_rd       = w_wb_wen ? r_rd : 5'd0;
   assign o_wb_rd_wdata = w_wb_wen ? r_rd_wdata : '0;

   assign o_cmt_valid = w_cmt_valid;
   assign o_cmt_pc    = w_cmt_valid ? r_pc : '0;
   assign o_cmt_inst  = w_cmt_valid ? r_inst : 32'd0;
   assign o_cmt_skip  = w_cmt_valid & r_skipcmt;
   assign o_cmt_wen   = w_wb_wen;
   assign o_cmt_wdest = w_cmt_valid ? r_rd : 5'd0;
   assign o_cmt_wdata = w_cmt_valid ? r_rd_wdata : '0;

   assign o_cycle_cnt = r_cycle_cnt;
   assign o_instr_cnt = r_instr_cnt;

   // fresh marks only the first VALID cycle after a latch, so a stall never repeats the commit.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_fresh <= 1'b0;
      end else begin
         r_fresh <= w_mem_hs;
         if (w_mem_hs) begin
            r_state <= S_VALID;
         end else if (w_wb_hs) begin
            r_state <= S_IDLE;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pc       <= '0;
         r_inst     <= 32'd0;
         r_rd       <= 5'd0;
         r_rd_wen   <= 1'b0;
         r_rd_wdata <= '0;
         r_nocmt    <= 1'b0;
         r_skipcmt  <= 1'b0;
      end else if (w_mem_hs) begin
         r_pc       <= i_wb_pc;
         r_inst     <= i_wb_inst;
         r_rd       <= i_wb_rd;
         r_rd_wen   <= i_wb_rd_wen;
         r_rd_wdata <= i_wb_rd_wdata;
         r_nocmt    <= i_wb_nocmt;
         r_skipcmt  <= i_wb_skipcmt;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cycle_cnt <= '0;
         r_instr_cnt <= '0;
      end else begin
         r_cycle_cnt <= r_cycle_cnt + CNT_ONE;
         if (w_cmt_valid) begin
            r_instr_cnt <= r_instr_cnt + CNT_ONE;
         end
      end
   end

endmodule

// File: tb/tb_wb_stage.sv
// Directed self-checking bench for wb_stage; counters are 4 bits wide so wrap is reachable.
module tb_wb_stage;

   localparam int XLEN  = 64;
   localparam int CNT_W = 4;

   logic             clk;
   logic             rst;
   logic             i_wb_memoryed_req;
   logic             o_wb_memoryed_ack;
   logic             o_wb_writebacked_req;
   logic             i_wb_writebacked_ack;
   logic [XLEN-1:0]  i_wb_pc;
   logic [31:0]      i_wb_inst;
   logic [4:0]       i_wb_rd;
   logic             i_wb_rd_wen;
   logic [XLEN-1:0]  i_wb_rd_wdata;
   logic             i_wb_nocmt;
   logic             i_wb_skipcmt;
   logic [4:0]       o_wb_rd;
   logic             o_wb_rd_wen;
   logic [XLEN-1:0]  o_wb_rd_wdata;
   logic             o_cmt_valid;
   logic [XLEN-1:0]  o_cmt_pc;
   logic [31:0]      o_cmt_inst;
   logic             o_cmt_skip;
   logic             o_cmt_wen;
   logic [4:0]       o_cmt_wdest;
   logic [XLEN-1:0]  o_cmt_wdata;
   logic [CNT_W-1:0] o_cycle_cnt;
   logic [CNT_W-1:0] o_instr_cnt;

   int         vectors;
   int         miscompares;
   int         edges;
   logic [3:0] expInstr;

   wb_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
      .clk                  (clk),
      .rst                  (rst),
      .i_wb_memoryed_req    (i_wb_memoryed_req),
      .o_wb_memoryed_ack    (o_wb_memoryed_ack),
      .o_wb_writebacked_req (o_wb_writebacked_req),
      .i_wb_writebacked_ack (i_wb_writebacked_ack),
      .i_wb_pc              (i_wb_pc),
      .i_wb_inst            (i_wb_inst),
      .i_wb_rd              (i_wb_rd),
      .i_wb_rd_wen          (i_wb_rd_wen),
      .i_wb_rd_wdata        (i_wb_rd_wdata),
      .i_wb_nocmt           (i_wb_nocmt),
      .i_wb_skipcmt         (i_wb_skipcmt),
      .o_wb_rd              (o_wb_rd),
      .o_wb_rd_wen          (o_wb_rd_wen),
      .o_wb_rd_wdata        (o_wb_rd_wdata),
      .o_cmt_valid          (o_cmt_valid),
      .o_cmt_pc             (o_cmt_pc),
      .o_cmt_inst           (o_cmt_inst),
      .o_cmt_skip           (o_cmt_skip),
      .o_cmt_wen            (o_cmt_wen),
      .o_cmt_wdest          (o_cmt_wdest),
      .o_cmt_wdata          (o_cmt_wdata),
      .o_cycle_cnt          (o_cycle_cnt),
      .o_instr_cnt          (o_instr_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Move to just after the next rising edge, where inputs are changed.
   task automatic step();
      @(posedge clk);
      #1;
      edges++;
   endtask

   // Move to the falling edge of the current cycle, where outputs are observed.
   task automatic sample();
      @(negedge clk);
   endtask

   task automatic driveInstr(input logic req, input logic [63:0] pc, input logic [4:0] rd,
                             input logic wen, input logic [63:0] wdata,
                             input logic nocmt, input logic skip);
      i_wb_memoryed_req = req;
      i_wb_pc           = pc;
      i_wb_inst         = pc[33:2];
      i_wb_rd           = rd;
      i_wb_rd_wen       = wen;
      i_wb_rd_wdata     = wdata;
      i_wb_nocmt        = nocmt;
      i_wb_skipcmt      = skip;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      i_wb_writebacked_ack = 1'b0;
      driveInstr(1'b0, 64'd0, 5'd0, 1'b0, 64'd0, 1'b0, 1'b0);
      #2;
      vectors++; if (o_wb_writebacked_req !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_wb_req: got %0d want 0", o_wb_writebacked_req); end
      vectors++; if (o_wb_memoryed_ack !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_mem_ack: got %0d want 0", o_wb_memoryed_ack); end
      vectors++; if (o_cmt_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_cmt_valid: got %0d want 0", o_cmt_valid); end
      vectors++; if (o_cycle_cnt !== 4'd0) begin miscompares++; $display("[TB] FAIL reset_cycle_cnt: got %0d want 0", o_cycle_cnt); end
      vectors++; if (o_instr_cnt !== 4'd0) begin miscompares++; $display("[TB] FAIL reset_instr_cnt: got %0d want 0", o_instr_cnt); end
      step();
      rst = 1'b0;
      edges = 0;
      expInstr = 4'd0;
      sample();
      vectors++; if (o_wb_memoryed_ack !== 1'b1) begin miscompares++; $display("[TB] FAIL idle_mem_ack: got %0d want 1", o_wb_memoryed_ack); end
      vectors++; if (o_wb_writebacked_req !== 1'b0) begin miscompares++; $display("[TB] FAIL idle_wb_req: got %0d want 0", o_wb_writebacked_req); end
   endtask

   task automatic test_single();
      step();
      i_wb_writebacked_ack = 1'b1;
      driveInstr(1'b1, 64'h8000_0000, 5'd5, 1'b1, 64'h1234, 1'b0, 1'b0);
      sample();
      vectors++; if (o_wb_memoryed_ack !== 1'b1) begin miscompares++; $display("[TB] FAIL single_mem_ack: got %0d want 1", o_wb_memoryed_ack); end
      vectors++; if (o_wb_rd_wen !== 1'b0) begin miscompares++; $display("[TB] FAIL single_early_wen: got %0d want 0", o_wb_rd_wen); end
      step();
      driveInstr(1'b0, 64'd0, 5'd0, 1'b0, 64'd0, 1'b0, 1'b0);
      sample();
      vectors++; if (o_wb_rd_wen !== 1'b1) begin miscompares++; $display("[TB] FAIL single_wen: got %0d want 1", o_wb_rd_wen); end
      vectors++; if (o_wb_rd !== 5'd5) begin miscompares++; $display("[TB] FAIL single_rd: got %0d want 5", o_wb_rd); end
      vectors++; if (o_wb_rd_wdata !== 64'h1234) begin miscompares++; $display("[TB] FAIL single_wdata: got %h want 1234", o_wb_rd_wdata); end
      vectors++; if (o_cmt_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL single_cmt_valid: got %0d want 1", o_cmt_valid); end
      vectors++; if (o_cmt_pc !== 64'h8000_0000) begin miscompares++; $display("[TB] FAIL single_cmt_pc: got %h want 80000000", o_cmt_pc); end
      vectors++; if (o_cmt_wen !== 1'b1) begin miscompares++; $display("[TB] FAIL single_cmt_wen: got %0d want 1", o_cmt_wen); end
      vectors++; if (o_instr_cnt !== expInstr) begin miscompares++; $display("[TB] FAIL single_instr_before: got %0d want %0d", o_instr_cnt, expInstr); end
      step();
      expInstr++;
      sample();
      vectors++; if (o_wb_rd_wen !== 1'b0) begin miscompares++; $display("[TB] FAIL single_wen_once: got %0d want 0", o_wb_rd_wen); end
      vectors++; if (o_cmt_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL single_cmt_once: got %0d want 0", o_cmt_valid); end
      vectors++; if (o_wb_rd !== 5'd0) begin miscompares++; $display("[TB] FAIL single_rd_zero: got %0d want 0", o_wb_rd); end
      vectors++; if (o_wb_writebacked_req !== 1'b0) begin miscompares++; $display("[TB] FAIL single_back_idle: got %0d want 0", o_wb_writebacked_req); end
      vectors++; if (o_instr_cnt !== expInstr) begin miscompares++; $display("[TB] FAIL single_instr_after: got %0d want %0d", o_instr_cnt, expInstr); end
      vectors++; if (o_cycle_cnt !== 4'(edges)) begin miscompares++; $display("[TB] FAIL single_cycle_cnt: got %0d want %0d", o_cycle_cnt, 4'(edges)); end
   endtask

   task automatic test_stall();
      step();
      i_wb_writebacked_ack = 1'b0;
      driveInstr(1'b1, 64'h8000_0010, 5'd7, 1'b1, 64'hA7, 1'b0, 1'b0);
      sample();
      step();
      driveInstr(1'b1, 64'h8000_0014, 5'd8, 1'b1, 64'hB8, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) begin
         sample();
         vectors++; if (o_wb_writebacked_req !== 1'b1) begin miscompares++; $display("[TB] FAIL stall_wb_req[%0d]: got %0d want 1", i, o_wb_writebacked_req); end
         vectors++; if (o_wb_memoryed_ack !== 1'b0) begin miscompares++; $display("[TB] FAIL stall_mem_ack[%0d]: got %0d want 0", i, o_wb_memoryed_ack); end
         vectors++; if (o_cmt_valid !== (i == 0)) begin miscompares++; $display("[TB] FAIL stall_cmt_valid[%0d]: got %0d want %0d", i, o_cmt_valid, (i == 0)); end
         vectors++; if (o_wb_rd_wen !== (i == 0)) begin miscompares++; $display("[TB] FAIL stall_wen[%0d]: got %0d want %0d", i, o_wb_rd_wen, (i == 0)); end
         if (i == 0) begin
            vectors++; if (o_cmt_wdest !== 5'd7) begin miscompares++; $display("[TB] FAIL stall_wdest: got %0d want 7", o_cmt_wdest); end
         end
         step();
         if (i == 0) expInstr++;
      end
      i_wb_writebacked_ack = 1'b1;
      sample();
      vectors++; if (o_wb_memoryed_ack !== 1'b1) begin miscompares++; $display("[TB] FAIL stall_release_ack: got %0d want 1", o_wb_memoryed_ack); end
      vectors++; if (o_cmt_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL stall_release_cmt: got %0d want 0", o_cmt_valid); end
      step();
      driveInstr(1'b0, 64'd0, 5'd0, 1'b0, 64'd0, 1'b0, 1'b0);
      sample();
      vectors++; if (o_cmt_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL stall_next_cmt: got %0d want 1", o_cmt_valid); end
      vectors++; if (o_cmt_wdest !== 5'd8) begin miscompares++; $display("[TB] FAIL stall_next_wdest: got %0d want 8", o_cmt_wdest); end
      vectors++; if (o_cmt_wdata !== 64'hB8) begin miscompares++; $display("[TB] FAIL stall_next_wdata: got %h want b8", o_cmt_wdata); end
      step();
      expInstr++;
      sample();
      vectors++; if (o_wb_writebacked_req !== 1'b0) begin miscompares++; $display("[TB] FAIL stall_end_idle: got %0d want 0", o_wb_writebacked_req); end
      vectors++; if (o_instr_cnt !== expInstr) begin miscompares++; $display("[TB] FAIL stall_instr_cnt: got %0d want %0d", o_instr_cnt, expInstr); end
   endtask

   task automatic test_back_to_back();
      step();
      i_wb_writebacked_ack = 1'b1;
      driveInstr(1'b1, 64'h8000_0100, 5'd1, 1'b1, 64'h11, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) begin
         step();
         if (i > 0) expInstr++;
         if (i < 2) driveInstr(1'b1, 64'h8000_0104 + 64'(4 * i), 5'(i + 2), 1'b1, 64'h22 + 64'(i * 'h11), 1'b0, 1'b0);
         else driveInstr(1'b0, 64'd0, 5'd0, 1'b0, 64'd0, 1'b0, 1'b0);
         sample();
         vectors++; if (o_cmt_valid !== (i < 3)) begin miscompares++; $display("[TB] FAIL b2b_cmt_valid[%0d]: got %0d want %0d", i, o_cmt_valid, (i < 3)); end
         vectors++; if (o_wb_writebacked_req !== (i < 3)) begin miscompares++; $display("[TB] FAIL b2b_wb_req[%0d]: got %0d want %0d", i, o_wb_writebacked_req, (i < 3)); end
         if (i < 3) begin
            vectors++; if (o_cmt_wdest !== 5'(i + 1)) begin miscompares++; $display("[TB] FAIL b2b_wdest[%0d]: got %0d want %0d", i, o_cmt_wdest, i + 1); end
            vectors++; if (o_wb_memoryed_ack !== 1'b1) begin miscompares++; $display("[TB] FAIL b2b_mem_ack[%0d]: got %0d want 1", i, o_wb_memoryed_ack); end
         end
      end
      vectors++; if (o_instr_cnt !== expInstr) begin miscompares++; $display("[TB] FAIL b2b_instr_cnt: got %0d want %0d", o_instr_cnt, expInstr); end
   endtask

   task automatic test_filter();
      step();
      i_wb_writebacked_ack = 1'b1;
      driveInstr(1'b1, 64'h8000_0200, 5'd9, 1'b1, 64'h99, 1'b1, 1'b0);
      sample();
      step();
      driveInstr(1'b1, 64'h8000_0204, 5'd10, 1'b1, 64'hAA, 1'b0, 1'b1);
      sample();
      vectors++; if (o_wb_writebacked_req !== 1'b1) begin miscompares++; $display("[TB] FAIL nocmt_wb_req: got %0d want 1", o_wb_writebacked_req); end
      vectors++; if (o_cmt_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL nocmt_cmt_valid: got %0d want 0", o_cmt_valid); end
      vectors++; if (o_wb_rd_wen !== 1'b0) begin miscompares++; $display("[TB] FAIL nocmt_wen: got %0d want 0", o_wb_rd_wen); end
      step();
      driveInstr(1'b1, 64'h8000_0208, 5'd0, 1'b1, 64'h55, 1'b0, 1'b0);
      sample();
      vectors++; if (o_instr_cnt !== expInstr) begin miscompares++; $display("[TB] FAIL nocmt_instr_cnt: got %0d want %0d", o_instr_cnt, expInstr); end
      vectors++; if (o_cmt_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL skip_cmt_valid: got %0d want 1", o_cmt_valid); end
      vectors++; if (o_cmt_skip !== 1'b1) begin miscompares++; $display("[TB] FAIL skip_cmt_skip: got %0d want 1", o_cmt_skip); end
      vectors++; if (o_wb_rd !== 5'd10) begin miscompares++; $display("[TB] FAIL skip_rd: got %0d want 10", o_wb_rd); end
      step();
      expInstr++;
      driveInstr(1'b0, 64'd0, 5'd0, 1'b0, 64'd0, 1'b0, 1'b0);
      sample();
      vectors++; if (o_cmt_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL rd0_cmt_valid: got %0d want 1", o_cmt_valid); end
      vectors++; if (o_cmt_wen !== 1'b0) begin miscompares++; $display("[TB] FAIL rd0_cmt_wen: got %0d want 0", o_cmt_wen); end
      vectors++; if (o_wb_rd_wen !== 1'b0) begin miscompares++; $display("[TB] FAIL rd0_wen: got %0d want 0", o_wb_rd_wen); end
      vectors++; if (o_wb_rd_wdata !== 64'd0) begin miscompares++; $display("[TB] FAIL rd0_wdata_masked: got %h want 0", o_wb_rd_wdata); end
      vectors++; if (o_cmt_skip !== 1'b0) begin miscompares++; $display("[TB] FAIL rd0_cmt_skip: got %0d want 0", o_cmt_skip); end
      step();
      expInstr++;
      sample();
      vectors++; if (o_instr_cnt !== expInstr) begin miscompares++; $display("[TB] FAIL filter_instr_cnt: got %0d want %0d", o_instr_cnt, expInstr); end
   endtask

   task automatic test_async_reset();
      step();
      i_wb_writebacked_ack = 1'b0;
      driveInstr(1'b1, 64'h8000_0300, 5'd12, 1'b1, 64'hCC, 1'b0, 1'b0);
      sample();
      step();
      driveInstr(1'b0, 64'd0, 5'd0, 1'b0, 64'd0, 1'b0, 1'b0);
      sample();
      vectors++; if (o_cmt_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL areset_pre_cmt: got %0d want 1", o_cmt_valid); end
      step();
      expInstr++;
      sample();
      vectors++; if (o_wb_writebacked_req !== 1'b1) begin miscompares++; $display("[TB] FAIL areset_holding: got %0d want 1", o_wb_writebacked_req); end
      #1;
      rst = 1'b1;
      #1;
      expInstr = 4'd0;
      vectors++; if (o_wb_writebacked_req !== 1'b0) begin miscompares++; $display("[TB] FAIL areset_wb_req: got %0d want 0", o_wb_writebacked_req); end
      vectors++; if (o_wb_memoryed_ack !== 1'b0) begin miscompares++; $display("[TB] FAIL areset_mem_ack: got %0d want 0", o_wb_memoryed_ack); end
      vectors++; if (o_cycle_cnt !== 4'd0) begin miscompares++; $display("[TB] FAIL areset_cycle_cnt: got %0d want 0", o_cycle_cnt); end
      vectors++; if (o_instr_cnt !== 4'd0) begin miscompares++; $display("[TB] FAIL areset_instr_cnt: got %0d want 0", o_instr_cnt); end
      step();
      rst = 1'b0;
      edges = 0;
      i_wb_writebacked_ack = 1'b1;
      sample();
      vectors++; if (o_cmt_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL areset_release_cmt: got %0d want 0", o_cmt_valid); end
      vectors++; if (o_cycle_cnt !== 4'd0) begin miscompares++; $display("[TB] FAIL areset_release_cycle: got %0d want 0", o_cycle_cnt); end
      step();
      sample();
      vectors++; if (o_cmt_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL areset_after_cmt: got %0d want 0", o_cmt_valid); end
      vectors++; if (o_wb_rd_wen !== 1'b0) begin miscompares++; $display("[TB] FAIL areset_after_wen: got %0d want 0", o_wb_rd_wen); end
      vectors++; if (o_cycle_cnt !== 4'd1) begin miscompares++; $display("[TB] FAIL areset_after_cycle: got %0d want 1", o_cycle_cnt); end
   endtask

   task automatic test_counter_wrap();
      logic pending;
      pending = 1'b0;
      step();
      i_wb_writebacked_ack = 1'b1;
      for (int i = 0; i < 18; i++) begin
         driveInstr(1'b1, 64'h8000_0400 + 64'(4 * i), 5'(i + 1), 1'b1, 64'(i), 1'b0, 1'b0);
         sample();
         vectors++; if (o_cmt_valid !== pending) begin miscompares++; $display("[TB] FAIL wrap_cmt_valid[%0d]: got %0d want %0d", i, o_cmt_valid, pending); end
         vectors++; if (o_cycle_cnt !== 4'(edges)) begin miscompares++; $display("[TB] FAIL wrap_cycle_cnt[%0d]: got %0d want %0d", i, o_cycle_cnt, 4'(edges)); end
         vectors++; if (o_instr_cnt !== expInstr) begin miscompares++; $display("[TB] FAIL wrap_instr_cnt[%0d]: got %0d want %0d", i, o_instr_cnt, expInstr); end
         step();
         if (pending) expInstr++;
         pending = 1'b1;
      end
      driveInstr(1'b0, 64'd0, 5'd0, 1'b0, 64'd0, 1'b0, 1'b0);
      sample();
      vectors++; if (o_instr_cnt !== expInstr) begin miscompares++; $display("[TB] FAIL wrap_final_instr: got %0d want %0d", o_instr_cnt, expInstr); end
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      edges       = 0;
      expInstr    = 4'd0;
      test_reset();
      test_single();
      test_stall();
      test_back_to_back();
      test_filter();
      test_async_reset();
      test_counter_wrap();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
